// File: rtl/tone_gen_spk.sv
// -----------------------------------------------------------------------------
// tone_gen_spk
//   Square-wave speaker driver fed by the note table's frequency preset.
//   A loadable up-counter runs from the latched preset to all-ones. Each wrap
//   reloads the counter from f_code, emits a one-cycle full_tick and toggles
//   spk, giving a tick spacing of (MAX_CODE - code + 1) cycles and a 50% duty
//   square wave of twice that period. The all-ones code is the rest code:
//   the counter wraps every cycle, spk is held low and rest is raised.
//
//   Optional feature macro: TONE_GATE_EN
//     Adds input tone_gate. While it is low the counter is parked at
//     MAX_CODE and spk/full_tick/code_ack are forced low, so the first edge
//     after it rises is a wrap and the tone restarts phase-aligned.
//     Without the macro the block behaves as if tone_gate were tied high.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       asynchronous active-high reset
//   tone_gate  in   1       tone enable (only with TONE_GATE_EN)
//   f_code     in   CODE_W  frequency preset, sampled only at a wrap
//   spk        out  1       speaker square wave (registered)
//   full_tick  out  1       one-cycle pulse per counter wrap (registered)
//   code_ack   out  1       pulse when a wrap latches a new code (registered)
//   rest       out  1       high while the latched code is the rest code
// -----------------------------------------------------------------------------
module tone_gen_spk #(
  parameter int unsigned CODE_W   = 11,
  parameter int unsigned MAX_CODE = 2**CODE_W - 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TONE_GATE_EN
  input  logic              tone_gate,
`endif
  input  logic [CODE_W-1:0] f_code,
  output logic              spk,
  output logic              full_tick,
  output logic              code_ack,
  output logic              rest
);

  localparam logic [CODE_W-1:0] MAX_V = CODE_W'(MAX_CODE);

  logic [CODE_W-1:0] cnt;
  logic [CODE_W-1:0] code_q;
  logic              gate;
  logic              wrap;
  logic              code_is_rest;

`ifdef TONE_GATE_EN
  assign gate = tone_gate;
`else
  assign gate = 1'b1;
`endif

  assign wrap         = (cnt == MAX_V);
  assign code_is_rest = (f_code == MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= MAX_V;
      code_q    <= MAX_V;
      spk       <= 1'b0;
      full_tick <= 1'b0;
      code_ack  <= 1'b0;
      rest      <= 1'b1;
    end else if (!gate) begin
      // Parking the counter at MAX_CODE makes the first gated-on edge a wrap;
      // code_q and rest deliberately keep their values.
      cnt       <= MAX_V;
      spk       <= 1'b0;
      full_tick <= 1'b0;
      code_ack  <= 1'b0;
    end else if (wrap) begin
      cnt       <= f_code;
      code_q    <= f_code;
      full_tick <= 1'b1;
      code_ack  <= (f_code != code_q);
      rest      <= code_is_rest;
      spk       <= code_is_rest ? 1'b0 : ~spk;
    end else begin
      cnt       <= cnt + 1'b1;
      full_tick <= 1'b0;
      code_ack  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_gen_spk.sv
// -----------------------------------------------------------------------------
// tb_tone_gen_spk
//   Scoreboard bench for tone_gen_spk. Stimulus pushes the expected wrap
//   events (spacing since the previous wrap, spk, code_ack, rest) into a
//   queue; a monitor pops and compares on every full_tick it observes.
//   Define TONE_GATE_EN for both files to exercise the tone_gate port.
// -----------------------------------------------------------------------------
module tb_tone_gen_spk;

  logic        clk;
  logic        rst;
  logic [10:0] f_code;
  logic        gate_lvl;
  logic        spk;
  logic        full_tick;
  logic        code_ack;
  logic        rest;

  tone_gen_spk #(.CODE_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef TONE_GATE_EN
    .tone_gate (gate_lvl),
`endif
    .f_code    (f_code),
    .spk       (spk),
    .full_tick (full_tick),
    .code_ack  (code_ack),
    .rest      (rest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    bit s;
    bit a;
    bit r;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   cyc      = 0;
  int   last_tick = 0;
  logic prev_spk  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic push(input int gap, input bit s, input bit a, input bit r);
    exp_t e;
    e.gap = gap; e.s = s; e.a = a; e.r = r;
    exp_q.push_back(e);
  endtask

  // Reset at a negedge, load the code, release one cycle later.
  task automatic start_phase(input logic [10:0] code);
    @(negedge clk);
    rst    = 1'b1;
    f_code = code;
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_expected_ticks", exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        last_tick = cyc;
        prev_spk  = spk;
      end else begin
        if (gate_lvl && spk != prev_spk)
          check("spk_changes_only_on_wrap", int'(full_tick), 1);
        if (code_ack)
          check("code_ack_only_on_wrap", int'(full_tick), 1);
        if (mon_en && full_tick) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tick", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("tick_spacing", cyc - last_tick, e.gap);
            check("tick_spk", int'(spk), int'(e.s));
            check("tick_code_ack", int'(code_ack), int'(e.a));
            check("tick_rest", int'(rest), int'(e.r));
          end
        end
        if (full_tick) last_tick = cyc;
        prev_spk = spk;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    f_code   = '0;
    gate_lvl = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_spk", int'(spk), 0);
    check("reset_full_tick", int'(full_tick), 0);
    check("reset_code_ack", int'(code_ack), 0);
    check("reset_rest", int'(rest), 1);

    // 7FE: tick every 2 cycles, spk period 4
    start_phase(11'h7FE);
    push(1, 1, 1, 0);
    push(2, 0, 0, 0);
    push(2, 1, 0, 0);
    push(2, 0, 0, 0);
    push(2, 1, 0, 0);
    drain(50);

    // 305: spacing 1275
    start_phase(11'h305);
    push(1, 1, 1, 0);
    push(1275, 0, 0, 0);
    push(1275, 1, 0, 0);
    drain(3000);

    // 6C0 -> 40C mid-period: 320-cycle period finishes, then 1012
    start_phase(11'h6C0);
    push(1, 1, 1, 0);
    push(320, 0, 0, 0);
    push(320, 1, 1, 0);
    push(1012, 0, 0, 0);
    push(1012, 1, 0, 0);
    repeat (421) @(negedge clk);
    f_code = 11'h40C;
    drain(3000);

    // Into rest and back out to 582 (spacing 638)
    start_phase(11'h7FE);
    push(1, 1, 1, 0);
    push(2, 0, 1, 1);
    for (int i = 0; i < 7; i++) push(1, 0, 0, 1);
    push(1, 1, 1, 0);
    push(638, 0, 0, 0);
    push(638, 1, 0, 0);
    repeat (2) @(negedge clk);
    f_code = 11'h7FF;
    repeat (8) @(negedge clk);
    f_code = 11'h582;
    drain(2000);

    // Async reset while spk is high, then first edge loads f_code
    start_phase(11'h7FE);
    push(1, 1, 1, 0);
    push(1, 1, 1, 0);
    push(638, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_spk", int'(spk), 1);
    check("pre_rst_full_tick", int'(full_tick), 1);
    check("pre_rst_rest", int'(rest), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_spk", int'(spk), 0);
    check("async_rst_rest", int'(rest), 1);
    check("async_rst_full_tick", int'(full_tick), 0);
    check("async_rst_code_ack", int'(code_ack), 0);
    f_code = 11'h582;
    @(negedge clk);
    rst = 1'b0;
    drain(1000);

`ifdef TONE_GATE_EN
    // Gate low for 100 cycles at 5C8, then phase-aligned restart (spacing 568)
    start_phase(11'h5C8);
    push(1, 1, 1, 0);
    push(110, 1, 0, 0);
    push(568, 0, 0, 0);
    push(568, 1, 0, 0);
    repeat (10) @(negedge clk);
    gate_lvl = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i % 20 == 0) begin
        check("gated_spk", int'(spk), 0);
        check("gated_full_tick", int'(full_tick), 0);
      end
    end
    gate_lvl = 1'b1;
    drain(1500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
